// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM encoding, row drive
// patterns and small helpers for decoding the active-low column lines.
package keypad_pkg;

    localparam int KEY_W = 4;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } scan_state_e;

    localparam logic [3:0] ROW_DRIVE [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    // True when exactly one column line is pulled low.
    function automatic logic single_low(input logic [3:0] c);
        case (c)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: single_low = 1'b1;
            default:                            single_low = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] c);
        case (c)
            4'b1101: low_index = 2'd1;
            4'b1011: low_index = 2'd2;
            4'b0111: low_index = 2'd3;
            default: low_index = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/input_synchronizer.sv
// Two-flop synchronizer for asynchronous inputs; resets to all ones so
// idle pulled-up lines read as released.
module input_synchronizer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks one low row per scan tick, debounces a
// single-key press and its release, and reports the accepted key code.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       cols,
    output logic [3:0]       rows,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    output logic             key_held
);

    localparam logic [15:0] PRESC_MAX = 16'(SCAN_DIV - 1);
    localparam logic [3:0]  DEB_MAX   = 4'(DEBOUNCE_SCANS);

    logic [3:0]  cols_sync;
    logic [15:0] presc_q, presc_d;
    logic        tick;
    scan_state_e state_q;
    logic [1:0]  row_idx_q;
    logic [1:0]  cap_row_q;
    logic [1:0]  cap_col_q;
    logic [3:0]  cnt_q;
    logic        col_hit;
    logic [1:0]  col_idx;
    logic        all_high;

    input_synchronizer #(.WIDTH(4)) u_col_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (cols),
        .q_o     (cols_sync)
    );

    assign tick    = (presc_q == PRESC_MAX);
    assign presc_d = tick ? 16'd0 : presc_q + 16'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) presc_q <= 16'd0;
        else          presc_q <= presc_d;
    end

    assign col_hit  = single_low(cols_sync);
    assign col_idx  = low_index(cols_sync);
    assign all_high = &cols_sync;
    assign rows     = ROW_DRIVE[row_idx_q];

    // The row stays parked while a key is being debounced or held, so the
    // columns seen on each tick always belong to the captured row.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_SCAN;
            row_idx_q <= 2'd0;
            cap_row_q <= 2'd0;
            cap_col_q <= 2'd0;
            cnt_q     <= 4'd0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (tick) begin
                case (state_q)
                    ST_SCAN: begin
                        if (col_hit) begin
                            cap_row_q <= row_idx_q;
                            cap_col_q <= col_idx;
                            cnt_q     <= 4'd1;
                            state_q   <= ST_DEBOUNCE;
                        end else begin
                            row_idx_q <= row_idx_q + 2'd1;
                        end
                    end
                    ST_DEBOUNCE: begin
                        if (col_hit && col_idx == cap_col_q) begin
                            cnt_q <= cnt_q + 4'd1;
                            if (cnt_q + 4'd1 == DEB_MAX) begin
                                key_code  <= {cap_row_q, cap_col_q};
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                state_q   <= ST_HELD;
                            end
                        end else begin
                            state_q   <= ST_SCAN;
                            row_idx_q <= row_idx_q + 2'd1;
                        end
                    end
                    ST_HELD: begin
                        if (all_high) begin
                            cnt_q   <= 4'd1;
                            state_q <= ST_RELEASE;
                        end
                    end
                    ST_RELEASE: begin
                        if (all_high) begin
                            cnt_q <= cnt_q + 4'd1;
                            if (cnt_q + 4'd1 == DEB_MAX) begin
                                key_held  <= 1'b0;
                                state_q   <= ST_SCAN;
                                row_idx_q <= row_idx_q + 2'd1;
                            end
                        end else begin
                            cnt_q   <= 4'd0;
                            state_q <= ST_HELD;
                        end
                    end
                    default: state_q <= ST_SCAN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized and directed bench for keypad_scanner with a keypad matrix
// model on the pins and a tick-level behavioural reference.
module tb_keypad_scanner;

    localparam int DIV = 4;
    localparam int DEB = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  cols;
    logic [3:0]  rows;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] press_mask = 16'h0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    keypad_scanner #(.SCAN_DIV(DIV), .DEBOUNCE_SCANS(DEB)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cols      (cols),
        .rows      (rows),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    // Pressed switch at (r,c) shorts row r to column c.
    function automatic logic [3:0] kp_cols(input logic [3:0] r, input logic [15:0] mask);
        logic [3:0] c;
        c = 4'hF;
        for (int ri = 0; ri < 4; ri++)
            for (int ci = 0; ci < 4; ci++)
                if (mask[ri*4+ci] && !r[ri]) c[ci] = 1'b0;
        return c;
    endfunction

    assign cols = kp_cols(rows, press_mask);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: tracks which row is scanned, how many consecutive ticks
    // agreed, and whether a key is idle/confirming/down/releasing.
    typedef enum {M_IDLE, M_CONFIRM, M_DOWN, M_UP} mode_e;
    mode_e      m_mode;
    int         m_idx, m_row, m_col, m_run, m_edges;
    logic [3:0] m_seen_q[$];
    logic [3:0] exp_rows, exp_code;
    logic       exp_valid, exp_held;
    logic [3:0] got_codes[$];

    function automatic int zeros(input logic [3:0] c);
        int n = 0;
        for (int i = 0; i < 4; i++) if (!c[i]) n++;
        return n;
    endfunction

    function automatic int first_zero(input logic [3:0] c);
        for (int i = 0; i < 4; i++) if (!c[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_idx = 0; m_row = 0; m_col = 0; m_run = 0; m_edges = 0;
        m_seen_q = '{4'hF, 4'hF};
        exp_rows = 4'b1110; exp_code = 4'h0; exp_valid = 1'b0; exp_held = 1'b0;
    endtask

    task automatic model_edge();
        logic [3:0] raw, seen;
        logic       is_tick;
        raw  = kp_cols(exp_rows, press_mask);
        seen = m_seen_q.pop_front();
        m_seen_q.push_back(raw);
        is_tick = (m_edges % DIV) == DIV - 1;
        m_edges++;
        exp_valid = 1'b0;
        if (is_tick) begin
            case (m_mode)
                M_IDLE:
                    if (zeros(seen) == 1) begin
                        m_row = m_idx; m_col = first_zero(seen); m_run = 1; m_mode = M_CONFIRM;
                    end else m_idx = (m_idx + 1) % 4;
                M_CONFIRM:
                    if (zeros(seen) == 1 && first_zero(seen) == m_col) begin
                        m_run++;
                        if (m_run == DEB) begin
                            exp_code = 4'(m_row * 4 + m_col); exp_valid = 1'b1; m_mode = M_DOWN;
                        end
                    end else begin
                        m_mode = M_IDLE; m_idx = (m_idx + 1) % 4;
                    end
                M_DOWN:
                    if (seen == 4'hF) begin m_run = 1; m_mode = M_UP; end
                M_UP:
                    if (seen == 4'hF) begin
                        m_run++;
                        if (m_run == DEB) begin m_mode = M_IDLE; m_idx = (m_idx + 1) % 4; end
                    end else begin
                        m_run = 0; m_mode = M_DOWN;
                    end
            endcase
        end
        exp_held = (m_mode == M_DOWN) || (m_mode == M_UP);
        exp_rows = 4'hF & ~(4'b0001 << m_idx);
    endtask

    task automatic compare_all();
        check("rows", rows, exp_rows);
        check("rows_one_low", zeros(rows), 1);
        check("key_valid", key_valid, exp_valid);
        check("key_held", key_held, exp_held);
        check("key_code", key_code, exp_code);
    endtask

    task automatic step();
        @(posedge clk);
        if (reset_n) model_edge();
        @(negedge clk);
        compare_all();
        if (key_valid) begin
            got_codes.push_back(key_code);
            $display("key_valid code=%h at %0t", key_code, $time);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_down(input string tag);
        int k = 0;
        while (m_mode != M_DOWN && k < 200) begin step(); k++; end
        check({tag, "_timeout"}, (m_mode == M_DOWN), 1);
    endtask

    task automatic reset_now();
        reset_n = 1'b0;
        model_reset();
        #1;
        check("rst_rows", rows, 4'b1110);
        check("rst_valid", key_valid, 1'b0);
        check("rst_held", key_held, 1'b0);
        check("rst_code", key_code, 4'h0);
        cycles(3);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [15:0] m;
        int          hold, gap;
        model_reset();
        @(negedge clk);
        reset_now();

        // Idle scanning.
        got_codes.delete();
        cycles(64);
        check("idle_pulses", got_codes.size(), 0);
        $display("idle scan: %0d pulses", got_codes.size());

        // Row2/col1 held long enough to be accepted.
        got_codes.delete();
        press_mask = 16'h0200;
        cycles(40);
        check("k9_held", key_held, 1'b1);
        press_mask = 16'h0;
        cycles(40);
        check("k9_pulses", got_codes.size(), 1);
        if (got_codes.size() > 0) check("k9_code", got_codes[0], 4'h9);
        $display("press r2c1: %0d pulses", got_codes.size());

        // Same key for only two matching ticks: press right as row2 starts.
        got_codes.delete();
        begin
            int k = 0;
            logic [3:0] prev = exp_rows;
            step();
            while (!(exp_rows == 4'b1011 && prev != 4'b1011) && k < 100) begin
                prev = exp_rows; step(); k++;
            end
            check("row2_timeout", (k < 100), 1);
        end
        press_mask = 16'h0200;
        cycles(8);
        press_mask = 16'h0;
        cycles(40);
        check("short_pulses", got_codes.size(), 0);
        $display("short press: %0d pulses", got_codes.size());

        // Two keys in row0 are ghost-rejected.
        got_codes.delete();
        press_mask = 16'h0003;
        cycles(64);
        press_mask = 16'h0;
        cycles(16);
        check("dual_pulses", got_codes.size(), 0);
        $display("dual key row0: %0d pulses", got_codes.size());

        // Key F, release with a bounce, then key 0.
        got_codes.delete();
        press_mask = 16'h8000;
        wait_down("kf");
        cycles(8);
        press_mask = 16'h0;
        cycles(8);
        press_mask = 16'h8000;
        cycles(4);
        press_mask = 16'h0;
        cycles(60);
        press_mask = 16'h0001;
        cycles(60);
        press_mask = 16'h0;
        cycles(40);
        check("f0_pulses", got_codes.size(), 2);
        if (got_codes.size() == 2) begin
            check("f0_first", got_codes[0], 4'hF);
            check("f0_second", got_codes[1], 4'h0);
        end
        $display("F then 0: %0d pulses", got_codes.size());

        // Reset while held; the key must re-qualify from scratch.
        press_mask = 16'h0040;
        wait_down("k6");
        cycles(4);
        got_codes.delete();
        reset_now();
        cycles(60);
        check("rst_held_pulses", got_codes.size(), 1);
        if (got_codes.size() > 0) check("rst_held_code", got_codes[0], 4'h6);
        press_mask = 16'h0;
        cycles(40);
        $display("reset while held: %0d pulses", got_codes.size());

        // Random presses, mostly single keys, sometimes a second key.
        for (int t = 0; t < 10; t++) begin
            m = 16'h1 << $urandom_range(0, 15);
            if ($urandom_range(0, 3) == 0) m |= 16'h1 << $urandom_range(0, 15);
            hold = $urandom_range(0, 60);
            gap  = $urandom_range(20, 60);
            got_codes.delete();
            press_mask = m;
            cycles(hold);
            press_mask = 16'h0;
            cycles(gap);
            $display("random press mask=%h hold=%0d gap=%0d pulses=%0d", m, hold, gap, got_codes.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 50000, clk cycles per scan tick (1 kHz at 50 MHz); legal range 8..65535.
REQ-002 Parameter DEBOUNCE_SCANS, default 4, consecutive matching ticks needed to accept a press or release; legal range 2..15.
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 cols  input  4  keypad column lines, active-low (external pull-ups), asynchronous to clk.
REQ-006 rows  output  4  keypad row drive, active-low, one-hot-low.
REQ-007 key_code  output  4  code of last accepted key, row_index*4 + col_index.
REQ-008 key_valid  output  1  one-clk pulse when a key press is accepted.
REQ-009 key_held  output  1  high while an accepted key remains pressed.

Function
REQ-010 cols passes through a 2-flop synchronizer before any use; the raw input is never sampled directly.
REQ-011 Prescaler counts 0..SCAN_DIV-1 and wraps; a tick is the cycle in which it equals SCAN_DIV-1.
REQ-012 The row index (0..3) drives rows: idx0=1110, idx1=1101, idx2=1011, idx3=0111; at all times exactly one row is low.
REQ-013 At each tick, the FSM evaluates the synchronized cols against the row driven during the preceding tick period; rows updates only on ticks.
REQ-014 FSM states: SCAN, DEBOUNCE, HELD, RELEASE; all transitions occur only on ticks.
REQ-015 SCAN: if exactly one column is low -> capture row/col, debounce count=1, go DEBOUNCE, hold row; otherwise (none, or two or more low) advance row index mod 4, stay SCAN.
REQ-016 DEBOUNCE: same single column low -> count+1; reaching DEBOUNCE_SCANS -> latch key_code, pulse key_valid, go HELD. Any other pattern -> go SCAN, advance row.
REQ-017 HELD: key_held=1; all cols high -> count=1, go RELEASE; otherwise stay; row does not advance.
REQ-018 RELEASE: all cols high -> count+1; reaching DEBOUNCE_SCANS -> go SCAN, advance row; any column low -> go HELD (count cleared).
REQ-019 key_valid asserts for exactly one clk cycle, in the cycle after the accepting tick, once per press; it is never re-asserted while HELD/RELEASE.
REQ-020 key_code changes only when key_valid asserts, and holds its value otherwise (including across releases).
REQ-021 key_held is high in HELD and RELEASE, low in SCAN and DEBOUNCE.
REQ-022 Ghosting/multiple keys in one row are rejected; a second key in another row while HELD is ignored until release completes.
REQ-023 Worst-case press-to-key_valid latency: (4 + DEBOUNCE_SCANS) ticks plus 3 clk cycles.

Reset
REQ-024 While reset_n is low: prescaler=0, row index=0 (rows=1110), state=SCAN, counters=0, synchronizer flops=1111, key_code=0, key_valid=0, key_held=0.
REQ-025 Reset asserted mid-operation (any state) aborts the press; no key_valid is produced on deassertion for a key held through reset unless it completes a full DEBOUNCE from SCAN.

Structure
REQ-026 Package keypad_pkg holds the FSM state encoding, the row drive constants (ROW_DRIVE[0..3]), and the key code width (4).
REQ-027 The 2-flop synchronizer is sub-module input_synchronizer, parameterized by width, reset value all ones.

Verification (SCAN_DIV=4, DEBOUNCE_SCANS=3)
REQ-028 No key pressed, 64 cycles -> rows cycles 1110,1101,1011,0111 every 4 clks; key_valid never 1; key_held 0.
REQ-029 Key row2/col1 (cols=1101 whenever rows=1011), held 40 cycles -> one key_valid pulse, key_code=4'h9, key_held=1 until released.
REQ-030 Same key held for only 2 matching ticks then released -> no key_valid, FSM returns to SCAN, row advances.
REQ-031 Row0 with cols=1100 (two keys) -> no key_valid; rows continues cycling.
REQ-032 Press row3/col3 (code 4'hF), release with one-tick bounce mid-RELEASE, then full release, then press row0/col0 -> exactly two key_valid pulses, codes F then 0.
REQ-033 Reset asserted while HELD -> all outputs at REQ-024 values in the same cycle; key still pressed after deassertion -> one key_valid after full debounce.
